// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Used by rf_wb_fifo and rf_wb_arbiter.
package rf_pkg;

    localparam int REG_W    = 32;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        EMPTY,
        PEND,
        FORCE
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0]    rd;
        logic [REG_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO of pending MDU writeback results. The head is read combinationally
// so a queued result can reach the register-file port in the same cycle it is selected.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output wb_req_t       head,
    output logic          full,
    output logic          empty
);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter between pipeline writeback and queued MDU results, with a
// starvation-forced drain. Optional RAW/WAW scoreboard enabled by RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_we,
    input  logic [AW-1:0]    pipe_rd,
    input  logic [REG_W-1:0] pipe_wd,
    output logic             pipe_hold,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [AW-1:0]    mdu_rd,
    input  logic [REG_W-1:0] mdu_wd,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic             busy_stall,
    output logic             rf_we,
    output logic [AW-1:0]    rf_a3,
    output logic [REG_W-1:0] rf_wd
);

    localparam int CW = $clog2(DEPTH + 1);

    arb_state_t          state_reg;
    arb_state_t          state_next;
    logic [STARVE_W-1:0] starve_reg;
    logic [STARVE_W-1:0] starve_next;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    wb_req_t       fifo_head;
    wb_req_t       push_data;
    logic          fifo_full;
    logic          fifo_empty;

    logic pipe_valid;
    logic enq;
    logic deq;
    logic hold;

    // Writes to x0 never need the port.
    assign pipe_valid = pipe_we && (pipe_rd != '0);

    // In FORCE the head leaves unconditionally, so a full FIFO can still accept
    // a result that cycle; both terms come from registered state only.
    assign mdu_ready = !rst && (!fifo_full || (state_reg == FORCE));
    assign enq       = mdu_valid && mdu_ready && (mdu_rd != '0);

    assign push_data.rd = mdu_rd;
    assign push_data.wd = mdu_wd;

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enq),
        .push_data (push_data),
        .pop       (deq),
        .count     (fifo_count),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        deq         = 1'b0;
        hold        = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (enq) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (pipe_valid) begin
                    starve_next = starve_reg + STARVE_W'(1);
                end else begin
                    deq         = 1'b1;
                    starve_next = '0;
                end
            end
            FORCE: begin
                deq         = 1'b1;
                hold        = pipe_valid;
                starve_next = '0;
            end
            default: begin
                state_next  = EMPTY;
                starve_next = '0;
            end
        endcase

        count_after = fifo_count + CW'(enq) - CW'(deq);
        if (state_reg != EMPTY) begin
            if (count_after == '0) begin
                state_next = EMPTY;
            end else if (starve_next == STARVE_W'(MAX_STARVE)) begin
                state_next = FORCE;
            end else begin
                state_next = PEND;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        rf_a3     = pipe_rd;
        rf_wd     = pipe_wd;
        pipe_hold = 1'b0;
        if (!rst) begin
            if (deq) begin
                rf_we = 1'b1;
                rf_a3 = fifo_head.rd;
                rf_wd = fifo_head.wd;
            end else begin
                rf_we = pipe_valid;
            end
            pipe_hold = hold;
        end
    end

    // Occupancy is tracked by the FSM state; empty is kept for the FIFO's own users.
    logic unused_fifo;
    assign unused_fifo = fifo_empty;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREG-1:1] busy_reg;
    logic [NREG-1:1] busy_next;
    logic [NREG-1:0] busy_vec;

    assign busy_vec = {busy_reg, 1'b0};

    // A new issue to the same register outranks the drain of an older result.
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
        assign busy_next[gi] = (iss_valid && (iss_rd == AW'(gi))) ? 1'b1 :
                               (deq && (fifo_head.rd == AW'(gi))) ? 1'b0 :
                               busy_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_stall = !rst && (busy_vec[rs1] || busy_vec[rs2] ||
                                 (iss_valid && busy_vec[iss_rd]));
`else
    assign busy_stall = 1'b0;

    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, rs1, rs2};
`endif

endmodule
